alu_pipe_param: RTL and testbench

- Parametrised, registered successor to the fixed-width ALU DUV.
- Generic operand width; multi-cycle pipelined multiply with configurable latency.
- Split-arrival operand collection with timeout, plus explicit OUT_VALID/BUSY handshake.
- Sits behind the alu_if driver in the same environment; the reference model and scoreboard are parametrised on the same constants.

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/alu_mul_pipe.sv | 45 ++++
 rtl/alu_pipe_param.sv | 238 +++++++++++++++++++++++
 tb/tb_alu_pipe_param.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, state and operand-mask definitions for the pipelined ALU and its reference model.
package alu_pkg;

   localparam int CMD_W = 4;

   typedef enum logic [CMD_W-1:0] {
      A_ADD = 4'd0, A_SUB = 4'd1, A_ADD_CIN = 4'd2, A_SUB_CIN = 4'd3,
      A_INC_A = 4'd4, A_DEC_A = 4'd5, A_INC_B = 4'd6, A_DEC_B = 4'd7,
      A_CMP = 4'd8, A_MUL_INC = 4'd9, A_MUL_SHL = 4'd10, A_SADD = 4'd11, A_SSUB = 4'd12
   } arith_cmd_e;

   typedef enum logic [CMD_W-1:0] {
      L_AND = 4'd0, L_NAND = 4'd1, L_OR = 4'd2, L_NOR = 4'd3, L_XOR = 4'd4, L_XNOR = 4'd5,
      L_NOT_A = 4'd6, L_NOT_B = 4'd7, L_SHR1_A = 4'd8, L_SHL1_A = 4'd9,
      L_SHR1_B = 4'd10, L_SHL1_B = 4'd11, L_ROL_A_B = 4'd12, L_ROR_A_B = 4'd13
   } logic_cmd_e;

   typedef enum logic [1:0] {S_IDLE, S_WAIT_OP, S_MUL, S_DONE} state_e;

   typedef enum logic [1:0] {IV_NONE = 2'b00, IV_A = 2'b01, IV_B = 2'b10, IV_AB = 2'b11} inp_valid_e;

   // Illegal opcodes need nothing, so any non-empty INP_VALID captures them and flags ERR.
   function automatic logic [1:0] needs_operands(input logic mode, input logic [CMD_W-1:0] cmd);
      logic [1:0] need;
      need = IV_AB;
      if (mode) begin
         case (cmd)
            A_INC_A, A_DEC_A:     need = IV_A;
            A_INC_B, A_DEC_B:     need = IV_B;
            4'd13, 4'd14, 4'd15:  need = IV_NONE;
            default:              need = IV_AB;
         endcase
      end else begin
         case (cmd)
            L_NOT_A, L_SHR1_A, L_SHL1_A: need = IV_A;
            L_NOT_B, L_SHR1_B, L_SHL1_B: need = IV_B;
            4'd14, 4'd15:                need = IV_NONE;
            default:                     need = IV_AB;
         endcase
      end
      return need;
   endfunction

   function automatic logic is_mul(input logic mode, input logic [CMD_W-1:0] cmd);
      return mode && (cmd == A_MUL_INC || cmd == A_MUL_SHL);
   endfunction

endpackage

// File: rtl/alu_mul_pipe.sv
// Multiplier with MUL_LAT-1 register stages; the caller's output register supplies the last stage.
// Stages advance only while ce_i is high.
module alu_mul_pipe #(
   parameter int WIDTH   = 8,
   parameter int MUL_LAT = 3
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               ce_i,
   input  logic               vld_i,
   input  logic [WIDTH:0]     a_i,
   input  logic [WIDTH:0]     b_i,
   output logic               vld_o,
   output logic [2*WIDTH-1:0] prod_o
);

   logic [2*WIDTH-1:0] prod_c;
   assign prod_c = {{(WIDTH-1){1'b0}}, a_i} * {{(WIDTH-1){1'b0}}, b_i};

   if (MUL_LAT == 1) begin : g_comb
      assign vld_o  = vld_i;
      assign prod_o = prod_c;
   end else begin : g_pipe
      logic [2*WIDTH-1:0] prod_q [MUL_LAT-1];
      logic [MUL_LAT-2:0] vld_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            vld_q <= '0;
            for (int i = 0; i < MUL_LAT-1; i++) prod_q[i] <= '0;
         end else if (ce_i) begin
            vld_q[0]  <= vld_i;
            prod_q[0] <= prod_c;
            for (int i = 1; i < MUL_LAT-1; i++) begin
               vld_q[i]  <= vld_q[i-1];
               prod_q[i] <= prod_q[i-1];
            end
         end
      end

      assign vld_o  = vld_q[MUL_LAT-2];
      assign prod_o = prod_q[MUL_LAT-2];
   end

endmodule

// File: rtl/alu_pipe_param.sv
// Parametrised registered ALU: split-arrival operand collection with timeout, pipelined multiply,
// one-cycle OUT_VALID pulse; BUSY high while waiting for an operand or multiplying.
module alu_pipe_param import alu_pkg::*; #(
   parameter int WIDTH   = 8,
   parameter int MUL_LAT = 3,
   parameter int TIMEOUT = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               ce_i,
   input  logic               mode_i,
   input  logic [CMD_W-1:0]   cmd_i,
   input  logic [1:0]         inp_valid_i,
   input  logic               cin_i,
   input  logic [WIDTH-1:0]   opa_i,
   input  logic [WIDTH-1:0]   opb_i,
   output logic [2*WIDTH-1:0] res_o,
   output logic               cout_o,
   output logic               oflow_o,
   output logic               g_o,
   output logic               e_o,
   output logic               l_o,
   output logic               err_o,
   output logic               out_valid_o,
   output logic               busy_o
);

   localparam int SH_W  = $clog2(WIDTH);
   localparam int CNT_W = $clog2(TIMEOUT+1);
   localparam logic [WIDTH:0] ONE_X = {{WIDTH{1'b0}}, 1'b1};

   state_e             state_q, state_d, go_state;
   logic [CMD_W-1:0]   cmd_q, cmd_x;
   logic               mode_q, mode_x, cin_q, cin_x;
   logic [WIDTH-1:0]   a_q, b_q, a_x, b_x;
   logic [1:0]         got_q, got_d, in_x, need;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               cap, mul_start, tmo, mul_x, mul_vld;
   logic [WIDTH:0]     ma, mb, sum;
   logic [WIDTH-1:0]   lg;
   logic [SH_W-1:0]    amt;
   logic [2*WIDTH-1:0] alu_res, prod, res_q;
   logic               alu_cout, alu_of, alu_g, alu_e, alu_l, alu_err;
   logic               cout_q, oflow_q, g_q, e_q, l_q, err_q;

   // In WAIT_OP only the still-missing operand may be taken from the inputs.
   always_comb begin
      cmd_x  = cmd_q;
      mode_x = mode_q;
      cin_x  = cin_q;
      in_x   = IV_NONE;
      if (state_q == S_IDLE || state_q == S_DONE) begin
         cmd_x  = cmd_i;
         mode_x = mode_i;
         cin_x  = cin_i;
         in_x   = inp_valid_i;
      end else if (state_q == S_WAIT_OP) begin
         in_x = inp_valid_i & ~got_q;
      end
      a_x      = in_x[0] ? opa_i : a_q;
      b_x      = in_x[1] ? opb_i : b_q;
      need     = needs_operands(mode_x, cmd_x);
      mul_x    = is_mul(mode_x, cmd_x);
      go_state = mul_x ? ((MUL_LAT == 1) ? S_DONE : S_MUL) : S_DONE;
   end

   always_comb begin
      state_d   = state_q;
      got_d     = got_q;
      cnt_d     = cnt_q;
      cap       = 1'b0;
      mul_start = 1'b0;
      tmo       = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (state_q == S_DONE) state_d = S_IDLE;
            if (in_x != IV_NONE) begin
               if ((in_x & need) == need) begin
                  cap       = 1'b1;
                  got_d     = IV_AB;
                  mul_start = mul_x;
                  state_d   = go_state;
               end else if (need == IV_AB) begin
                  cap     = 1'b1;
                  got_d   = in_x;
                  cnt_d   = '0;
                  state_d = S_WAIT_OP;
               end
            end
         end
         S_WAIT_OP: begin
            if (in_x != IV_NONE) begin
               cap       = 1'b1;
               got_d     = IV_AB;
               mul_start = mul_x;
               state_d   = go_state;
            end else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
               tmo     = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_MUL:   if (mul_vld) state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      sum      = '0;
      lg       = '0;
      alu_cout = 1'b0;
      alu_of   = 1'b0;
      alu_g    = 1'b0;
      alu_e    = 1'b0;
      alu_l    = 1'b0;
      alu_err  = 1'b0;
      amt      = b_x[SH_W-1:0];
      if (mode_x) begin
         case (cmd_x)
            A_ADD:     sum = {1'b0, a_x} + {1'b0, b_x};
            A_SUB:     sum = {1'b0, a_x} - {1'b0, b_x};
            A_ADD_CIN: sum = {1'b0, a_x} + {1'b0, b_x} + (WIDTH+1)'(cin_x);
            A_SUB_CIN: sum = {1'b0, a_x} - {1'b0, b_x} - (WIDTH+1)'(cin_x);
            A_INC_A:   sum = {1'b0, a_x} + ONE_X;
            A_DEC_A:   sum = {1'b0, a_x} - ONE_X;
            A_INC_B:   sum = {1'b0, b_x} + ONE_X;
            A_DEC_B:   sum = {1'b0, b_x} - ONE_X;
            A_CMP: begin
               alu_g = a_x > b_x;
               alu_e = a_x == b_x;
               alu_l = a_x < b_x;
            end
            A_SADD: begin
               sum    = {a_x[WIDTH-1], a_x} + {b_x[WIDTH-1], b_x};
               alu_of = sum[WIDTH] ^ sum[WIDTH-1];
            end
            A_SSUB: begin
               sum    = {a_x[WIDTH-1], a_x} - {b_x[WIDTH-1], b_x};
               alu_of = sum[WIDTH] ^ sum[WIDTH-1];
            end
            A_MUL_INC, A_MUL_SHL: ;
            default:   alu_err = 1'b1;
         endcase
         if (cmd_x < A_CMP) alu_cout = sum[WIDTH];
      end else begin
         case (cmd_x)
            L_AND:    lg = a_x & b_x;
            L_NAND:   lg = ~(a_x & b_x);
            L_OR:     lg = a_x | b_x;
            L_NOR:    lg = ~(a_x | b_x);
            L_XOR:    lg = a_x ^ b_x;
            L_XNOR:   lg = ~(a_x ^ b_x);
            L_NOT_A:  lg = ~a_x;
            L_NOT_B:  lg = ~b_x;
            L_SHR1_A: lg = a_x >> 1;
            L_SHL1_A: lg = a_x << 1;
            L_SHR1_B: lg = b_x >> 1;
            L_SHL1_B: lg = b_x << 1;
            L_ROL_A_B, L_ROR_A_B: begin
               if (|b_x[WIDTH-1:SH_W]) alu_err = 1'b1;
               else if (cmd_x == L_ROL_A_B)
                  for (int i = 0; i < WIDTH; i++) lg[i] = a_x[SH_W'(i) - amt];
               else
                  for (int i = 0; i < WIDTH; i++) lg[i] = a_x[SH_W'(i) + amt];
            end
            default:  alu_err = 1'b1;
         endcase
      end
      alu_res = mode_x ? {{(WIDTH-1){1'b0}}, sum} : {{WIDTH{1'b0}}, lg};
   end

   assign ma = (cmd_x == A_MUL_INC) ? ({1'b0, a_x} + ONE_X) : {1'b0, a_x << 1};
   assign mb = (cmd_x == A_MUL_INC) ? ({1'b0, b_x} + ONE_X) : {1'b0, b_x};

   alu_mul_pipe #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) u_mul (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .ce_i   (ce_i),
      .vld_i  (mul_start),
      .a_i    (ma),
      .b_i    (mb),
      .vld_o  (mul_vld),
      .prod_o (prod)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         got_q   <= IV_NONE;
         cnt_q   <= '0;
         cmd_q   <= '0;
         mode_q  <= 1'b0;
         cin_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
      end else if (ce_i) begin
         state_q <= state_d;
         got_q   <= got_d;
         cnt_q   <= cnt_d;
         if (cap) begin
            cmd_q  <= cmd_x;
            mode_q <= mode_x;
            cin_q  <= cin_x;
            a_q    <= a_x;
            b_q    <= b_x;
         end
      end
   end

   // Result registers load only on entry to DONE, so they hold between pulses.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         {res_q, cout_q, oflow_q, g_q, e_q, l_q, err_q} <= '0;
      end else if (ce_i && state_d == S_DONE) begin
         if (tmo)
            {res_q, cout_q, oflow_q, g_q, e_q, l_q, err_q} <= {{(2*WIDTH+5){1'b0}}, 1'b1};
         else if (mul_vld)
            {res_q, cout_q, oflow_q, g_q, e_q, l_q, err_q} <= {prod, 6'b0};
         else if (alu_err)
            {res_q, cout_q, oflow_q, g_q, e_q, l_q, err_q} <= {{(2*WIDTH+5){1'b0}}, 1'b1};
         else
            {res_q, cout_q, oflow_q, g_q, e_q, l_q, err_q} <=
               {alu_res, alu_cout, alu_of, alu_g, alu_e, alu_l, 1'b0};
      end
   end

   assign res_o       = res_q;
   assign cout_o      = cout_q;
   assign oflow_o     = oflow_q;
   assign g_o         = g_q;
   assign e_o         = e_q;
   assign l_o         = l_q;
   assign err_o       = err_q;
   assign out_valid_o = ce_i && (state_q == S_DONE);
   assign busy_o      = (state_q == S_WAIT_OP) || (state_q == S_MUL);

endmodule

// File: tb/tb_alu_pipe_param.sv
// Directed scoreboard bench for alu_pipe_param at WIDTH=8, MUL_LAT=3, TIMEOUT=16.
module tb_alu_pipe_param;

   logic        clk = 1'b0;
   logic        rst_n, ce, mode, cin;
   logic [3:0]  cmd;
   logic [1:0]  iv;
   logic [7:0]  opa, opb;
   logic [15:0] res;
   logic        cout, oflow, g, e, l, err, out_valid, busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      string       name;
      logic [21:0] v;
      int          at;
   } exp_t;
   exp_t sb[$];

   alu_pipe_param #(.WIDTH(8), .MUL_LAT(3), .TIMEOUT(16)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .ce_i        (ce),
      .mode_i      (mode),
      .cmd_i       (cmd),
      .inp_valid_i (iv),
      .cin_i       (cin),
      .opa_i       (opa),
      .opb_i       (opb),
      .res_o       (res),
      .cout_o      (cout),
      .oflow_o     (oflow),
      .g_o         (g),
      .e_o         (e),
      .l_o         (l),
      .err_o       (err),
      .out_valid_o (out_valid),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [21:0] pk(input logic [15:0] r, input logic co, input logic of,
                                      input logic gg, input logic ee, input logic ll, input logic er);
      return {r, co, of, gg, ee, ll, er};
   endfunction

   always @(negedge clk) begin : monitor
      exp_t        x;
      logic [21:0] act;
      if (rst_n && out_valid) begin
         act    = {res, cout, oflow, g, e, l, err};
         checks = checks + 1;
         if (sb.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_out cycle=%0d got=%h", cyc, act);
         end else begin
            x = sb.pop_front();
            if (act !== x.v || cyc != x.at) begin
               errors = errors + 1;
               $display("FAIL %s got=%h@%0d want=%h@%0d", x.name, act, cyc, x.v, x.at);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      checks = checks + 1;
      if (act !== want) begin
         errors = errors + 1;
         $display("FAIL %s got=%h want=%h", nm, act, want);
      end
   endtask

   task automatic settle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input logic m, input logic [3:0] c, input logic [1:0] v,
                        input logic [7:0] a, input logic [7:0] b, input logic ci);
      mode = m; cmd = c; iv = v; opa = a; opb = b; cin = ci;
      @(posedge clk);
      #1;
      iv = 2'b00;
   endtask

   task automatic op(input string nm, input logic m, input logic [3:0] c, input logic [1:0] v,
                     input logic [7:0] a, input logic [7:0] b, input logic ci,
                     input logic [21:0] ex, input int lat);
      exp_t x;
      x.name = nm;
      x.v    = ex;
      x.at   = cyc + lat;
      sb.push_back(x);
      issue(m, c, v, a, b, ci);
   endtask

   initial begin
      rst_n = 1'b0; ce = 1'b1; mode = 1'b0; cmd = 4'h0; iv = 2'b00;
      opa = 8'h00; opb = 8'h00; cin = 1'b0;
      #12;
      chk("reset_outputs", {res, cout, oflow, g, e, l, err, out_valid, busy}, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      settle(1);

      // Back-to-back single-cycle ops; each is captured in the previous op's DONE cycle.
      op("add_ff_01",  1, 4'd0,  2'b11, 8'hFF, 8'h01, 0, pk(16'h0100, 1, 0, 0, 0, 0, 0), 1);
      op("sub_cin",    1, 4'd3,  2'b11, 8'h05, 8'h05, 1, pk(16'h01FF, 1, 0, 0, 0, 0, 0), 1);
      op("ssub_ovf",   1, 4'd12, 2'b11, 8'h80, 8'h01, 0, pk(16'h017F, 0, 1, 0, 0, 0, 0), 1);
      op("cmp_lt",     1, 4'd8,  2'b11, 8'h05, 8'h07, 0, pk(16'h0000, 0, 0, 0, 0, 1, 0), 1);
      op("sadd_ovf",   1, 4'd11, 2'b11, 8'h7F, 8'h01, 0, pk(16'h0080, 0, 1, 0, 0, 0, 0), 1);
      settle(3);
      chk("hold_after_pulse", {res, oflow}, {15'h0, 16'h0080, 1'b1});

      op("inc_a",      1, 4'd4,  2'b01, 8'hFF, 8'h00, 0, pk(16'h0100, 1, 0, 0, 0, 0, 0), 1);
      issue(1, 4'd4, 2'b10, 8'h11, 8'h22, 0);
      op("dec_b",      1, 4'd7,  2'b10, 8'h00, 8'h00, 0, pk(16'h01FF, 1, 0, 0, 0, 0, 0), 1);
      op("nand",       0, 4'd1,  2'b11, 8'hF0, 8'h3C, 0, pk(16'h00CF, 0, 0, 0, 0, 0, 0), 1);
      op("xnor",       0, 4'd5,  2'b11, 8'hF0, 8'h3C, 0, pk(16'h0033, 0, 0, 0, 0, 0, 0), 1);
      op("shl1_b",     0, 4'd11, 2'b10, 8'h00, 8'h81, 0, pk(16'h0002, 0, 0, 0, 0, 0, 0), 1);
      op("illegal_op", 0, 4'd14, 2'b11, 8'h12, 8'h34, 0, pk(16'h0000, 0, 0, 0, 0, 0, 1), 1);
      op("rol_81_01",  0, 4'd12, 2'b11, 8'h81, 8'h01, 0, pk(16'h0003, 0, 0, 0, 0, 0, 0), 1);
      op("rol_bad_amt",0, 4'd12, 2'b11, 8'h81, 8'h10, 0, pk(16'h0000, 0, 0, 0, 0, 0, 1), 1);
      op("ror_81_01",  0, 4'd13, 2'b11, 8'h81, 8'h01, 0, pk(16'h00C0, 0, 0, 0, 0, 0, 0), 1);
      settle(2);

      op("mul_inc",    1, 4'd9,  2'b11, 8'h03, 8'h04, 0, pk(16'h0014, 0, 0, 0, 0, 0, 0), 3);
      chk("mul_busy_c1", busy, 1);
      issue(1, 4'd0, 2'b11, 8'h11, 8'h22, 0);
      chk("mul_busy_c2", busy, 1);
      settle(1);
      chk("mul_busy_done", busy, 0);
      settle(1);
      op("mul_shl",    1, 4'd10, 2'b11, 8'h81, 8'h03, 0, pk(16'h0006, 0, 0, 0, 0, 0, 0), 3);
      settle(3);
      op("mul_max",    1, 4'd9,  2'b11, 8'hFF, 8'hFE, 0, pk(16'hFF00, 0, 0, 0, 0, 0, 0), 3);
      settle(3);

      // Split arrival: B five cycles after A; CMD/MODE while waiting must be ignored.
      op("sub_split",  1, 4'd1,  2'b01, 8'h10, 8'h00, 0, pk(16'h000D, 0, 0, 0, 0, 0, 0), 6);
      chk("wait_busy", busy, 1);
      settle(4);
      issue(0, 4'd15, 2'b10, 8'h00, 8'h03, 0);
      settle(2);
      op("sub_timeout",1, 4'd1,  2'b01, 8'h10, 8'h00, 0, pk(16'h0000, 0, 0, 0, 0, 0, 1), 17);
      settle(17);
      settle(2);

      op("mul_ce_hold",1, 4'd9,  2'b11, 8'h02, 8'h02, 0, pk(16'h0009, 0, 0, 0, 0, 0, 0), 7);
      ce = 1'b0;
      settle(4);
      chk("ce_busy_hold", busy, 1);
      ce = 1'b1;
      settle(4);

      issue(1, 4'd9, 2'b11, 8'h05, 8'h05, 0);
      rst_n = 1'b0;
      #1;
      chk("reset_mid_mul", {res, cout, oflow, g, e, l, err, out_valid, busy}, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      settle(6);
      op("add_after_rst", 1, 4'd0, 2'b11, 8'h01, 8'h02, 0, pk(16'h0003, 0, 0, 0, 0, 0, 0), 1);
      settle(3);

      chk("scoreboard_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
